multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Parametrised multi-cycle successor to the single-cycle RV32I main decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Stalls on a memory ready handshake and traps on memory timeout or illegal opcode.
- Drives the datapath muxes, enables and ALU control for the shared-memory multi-cycle core.

Parameters:
- OPCODE_W, 7, opcode field width.
- ALUOP_W, 2, ALUOp width (≥2); values zero-extended.
- TIMEOUT, 15, max consecutive wait cycles before timeout trap; 0 disables timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Opcode  in  OPCODE_W  from instruction register; stable from DECODE until instruction completes.
- mem_ready  in  1  memory handshake; access completes in a cycle where request and mem_ready are both 1.
- PCWrite  out  1  unconditional PC load.
- Branch  out  1  conditional PC load (PC loads if Branch & zero).
- IorD  out  1  memory address select: 0=PC, 1=ALUOut.
- IRWrite  out  1  instruction register load.
- MemRead  out  1  read request.
- MemWrite  out  1  write request.
- MemtoReg  out  2  writeback select: 00=ALUOut, 01=MDR, 10=PC.
- Regwrite  out  1  register file write enable.
- ALUSrcA  out  2  A select: 00=PC, 01=rs1, 10=oldPC.
- ALUSrcB  out  2  B select: 00=rs2, 01=const 4, 10=imm.
- ALUOp  out  ALUOP_W  00=add, 01=sub/compare, 10=R-funct, 11=I-funct.
- PCSource  out  1  0=ALU result, 1=ALUOut.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
- timeout_err  out  1  sticky; set on memory timeout.
- illegal_op  out  1  sticky; set on illegal opcode (feature-dependent).

Behaviour:
- Reset: state=IDLE, all outputs 0, sticky flags and wait counter cleared; asynchronous, so reset mid-instruction aborts immediately.
- Outputs are combinational from state (Moore); IRWrite, PCWrite and instr_done in wait states are additionally gated by mem_ready.
- Unlisted outputs are 0 in every state.
- IDLE: all outputs 0; → FETCH after one cycle.
- FETCH: MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00, PCSource=0.
  - mem_ready=1: IRWrite=1, PCWrite=1, → DECODE.
  - Otherwise stay in FETCH.
- DECODE: ALUSrcA=10, ALUSrcB=10, ALUOp=00 (branch/jump target into ALUOut). Next state by Opcode:
  - 0110011 → EXEC_R.
  - 0010011 → EXEC_I.
  - 0000011 or 0100011 → MEM_ADDR.
  - 1100011 → BRANCH.
  - 1101111 → JAL.
  - Other → see Optional Feature.
- EXEC_R: ALUSrcA=01, ALUSrcB=00, ALUOp=10; → WB_ALU.
- EXEC_I: ALUSrcA=01, ALUSrcB=10, ALUOp=11; → WB_ALU.
- WB_ALU: Regwrite=1, MemtoReg=00, instr_done=1; → FETCH.
- MEM_ADDR: ALUSrcA=01, ALUSrcB=10, ALUOp=00; → MEM_RD (load) or MEM_WR (store).
- MEM_RD: MemRead=1, IorD=1; mem_ready → WB_MEM.
- WB_MEM: Regwrite=1, MemtoReg=01, instr_done=1; → FETCH.
- MEM_WR: MemWrite=1, IorD=1; mem_ready → instr_done=1, → FETCH.
- BRANCH: ALUSrcA=01, ALUSrcB=00, ALUOp=01, Branch=1, PCSource=1, instr_done=1; → FETCH.
- JAL: PCWrite=1, PCSource=1, Regwrite=1, MemtoReg=10 (PC already holds PC+4), instr_done=1; → FETCH.
- TRAP: all control outputs 0; absorbing until reset.
- Wait counter (width clog2(TIMEOUT+1)):
  - Cleared on entry to FETCH/MEM_RD/MEM_WR and whenever mem_ready=1.
  - Increments each cycle in those states with mem_ready=0.
  - Counter==TIMEOUT with mem_ready=0 → TRAP, timeout_err=1.
  - mem_ready in the same cycle as expiry: completion wins.
- Minimum latencies with zero wait: R/I/load-less = 4 cycles FETCH→FETCH; load 5; store 4; branch 3; JAL 3.

Optional Feature:
- ILLEGAL_TRAP_EN defined: unknown opcode in DECODE → TRAP, illegal_op=1 (sticky), no instr_done.
- Undefined: unknown opcode → FETCH as NOP with instr_done=1; illegal_op tied 0.

Decomposition:
- Package ctrl_pkg holds:
  - Opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL).
  - State enum typedef.
  - ALUOp, MemtoReg, ALUSrcA and ALUSrcB encodings.
- One sub-module: mem_wait_timer (wait counter plus expiry flag), reused for all three wait states.

Test Plan:
- Reset release, Opcode=0110011, mem_ready=1 → IDLE, FETCH(IRWrite=1, PCWrite=1), DECODE, EXEC_R(ALUOp=10), WB_ALU(Regwrite=1, instr_done=1).
- Load 0000011 with mem_ready low 3 cycles in MEM_RD → MEM_RD held 4 cycles, then WB_MEM MemtoReg=01, Regwrite=1.
- Store 0100011 → MEM_WR MemWrite=1, IorD=1, Regwrite=0; instr_done coincident with mem_ready.
- Branch 1100011 → BRANCH Branch=1, ALUOp=01, PCWrite=0; JAL 1101111 → PCWrite=1, MemtoReg=10.
- TIMEOUT=15, mem_ready held 0 in FETCH → TRAP after 16 cycles, timeout_err=1; mem_ready=1 on cycle 16 → DECODE, no error.
- Opcode=1111111: ILLEGAL_TRAP_EN → TRAP, illegal_op=1 until rst_n low; without macro → FETCH, instr_done=1. Assert rst_n=0 mid-MEM_RD → outputs 0 immediately.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, FSM states
// and the datapath mux / ALUOp select codes.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_ALU   = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_RFUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IFUNCT = 2'b11;

    localparam logic [1:0] MEMTOREG_ALU = 2'b00;
    localparam logic [1:0] MEMTOREG_MDR = 2'b01;
    localparam logic [1:0] MEMTOREG_PC  = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS1   = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    // States that hold a memory request open and wait on mem_ready.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_control_unit_mem_wait_timer.sv
// Consecutive wait-cycle counter shared by every memory wait state; flags
// expiry when the limit is reached while memory is still not ready.
module mem_wait_timer
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic mem_ready,
    output logic expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] count;

    // Leaving a wait state or completing the access resets the count, so each
    // wait state starts from zero on entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!active || mem_ready) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (TIMEOUT != 0) && active && !mem_ready && (count == LIMIT);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I main control FSM (fetch/decode/execute/memory/writeback).
// Optional build macro ILLEGAL_TRAP_EN: unknown opcodes trap instead of acting as NOP.
module multicycle_control_unit
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 7,
    parameter int ALUOP_W  = 2,
    parameter int TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                Branch,
    output logic                IorD,
    output logic                IRWrite,
    output logic                MemRead,
    output logic                MemWrite,
    output logic [1:0]          MemtoReg,
    output logic                Regwrite,
    output logic [1:0]          ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic                PCSource,
    output logic                instr_done,
    output logic                timeout_err,
    output logic                illegal_op
);

    state_t state;
    state_t next_state;

    logic wait_active;
    logic timer_expired;
    logic is_r;
    logic is_i;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_jal;
    logic set_timeout;

    assign is_r      = (Opcode == OPCODE_W'(OP_R));
    assign is_i      = (Opcode == OPCODE_W'(OP_I));
    assign is_load   = (Opcode == OPCODE_W'(OP_LOAD));
    assign is_store  = (Opcode == OPCODE_W'(OP_STORE));
    assign is_branch = (Opcode == OPCODE_W'(OP_BRANCH));
    assign is_jal    = (Opcode == OPCODE_W'(OP_JAL));

    assign wait_active = is_wait_state(state);
    assign set_timeout = timer_expired;

    mem_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .active   (wait_active),
        .mem_ready(mem_ready),
        .expired  (timer_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
        end else if (set_timeout) begin
            timeout_err <= 1'b1;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic set_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_op <= 1'b0;
        end else if (set_illegal) begin
            illegal_op <= 1'b1;
        end
    end
`else
    assign illegal_op = 1'b0;
`endif

    // Moore decode of the control word; only the wait states look at mem_ready
    // to qualify the loads and the completion pulse.
    always_comb begin
        next_state = state;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        IorD       = 1'b0;
        IRWrite    = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        MemtoReg   = MEMTOREG_ALU;
        Regwrite   = 1'b0;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        ALUOp      = ALUOP_W'(ALUOP_ADD);
        PCSource   = 1'b0;
        instr_done = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        set_illegal = 1'b0;
`endif

        case (state)
            S_IDLE: begin
                next_state = S_FETCH;
            end

            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                if (mem_ready) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    next_state = S_DECODE;
                end else if (timer_expired) begin
                    next_state = S_TRAP;
                end
            end

            // ALUOut captures oldPC + imm here so BRANCH/JAL can use it later.
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                if (is_r) begin
                    next_state = S_EXEC_R;
                end else if (is_i) begin
                    next_state = S_EXEC_I;
                end else if (is_load || is_store) begin
                    next_state = S_MEM_ADDR;
                end else if (is_branch) begin
                    next_state = S_BRANCH;
                end else if (is_jal) begin
                    next_state = S_JAL;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    set_illegal = 1'b1;
                    next_state  = S_TRAP;
`else
                    instr_done  = 1'b1;
                    next_state  = S_FETCH;
`endif
                end
            end

            S_EXEC_R: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_RS2;
                ALUOp      = ALUOP_W'(ALUOP_RFUNCT);
                next_state = S_WB_ALU;
            end

            S_EXEC_I: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                ALUOp      = ALUOP_W'(ALUOP_IFUNCT);
                next_state = S_WB_ALU;
            end

            S_WB_ALU: begin
                Regwrite   = 1'b1;
                MemtoReg   = MEMTOREG_ALU;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end

            S_MEM_ADDR: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                next_state = is_load ? S_MEM_RD : S_MEM_WR;
            end

            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    next_state = S_WB_MEM;
                end else if (timer_expired) begin
                    next_state = S_TRAP;
                end
            end

            S_WB_MEM: begin
                Regwrite   = 1'b1;
                MemtoReg   = MEMTOREG_MDR;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end

            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end else if (timer_expired) begin
                    next_state = S_TRAP;
                end
            end

            S_BRANCH: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_RS2;
                ALUOp      = ALUOP_W'(ALUOP_SUB);
                Branch     = 1'b1;
                PCSource   = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end

            // PC was already advanced to PC+4 in FETCH, so it is the link value.
            S_JAL: begin
                PCWrite    = 1'b1;
                PCSource   = 1'b1;
                Regwrite   = 1'b1;
                MemtoReg   = MEMTOREG_PC;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end

            S_TRAP: begin
                next_state = S_TRAP;
            end

            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed and randomized
// instruction streams checked cycle by cycle against a per-instruction model.
module tb_multicycle_control_unit;

    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] Opcode;
    logic       mem_ready;
    logic       PCWrite, Branch, IorD, IRWrite, MemRead, MemWrite;
    logic [1:0] MemtoReg;
    logic       Regwrite;
    logic [1:0] ALUSrcA, ALUSrcB, ALUOp;
    logic       PCSource, instr_done, timeout_err, illegal_op;

    int   n_cmp  = 0;
    int   n_fail = 0;
    logic exp_to;
    logic exp_ill;

    logic [18:0] act;
    logic [16:0] V_ZERO, V_FETCH, V_FETCH_RDY, V_DECODE, V_NOP, V_EXEC_R, V_EXEC_I;
    logic [16:0] V_WB_ALU, V_MEM_ADDR, V_MEM_RD, V_WB_MEM, V_MEM_WR, V_MEM_WR_RDY;
    logic [16:0] V_BRANCH, V_JAL;

    multicycle_control_unit #(
        .OPCODE_W(7),
        .ALUOP_W (2),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Opcode     (Opcode),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .Branch     (Branch),
        .IorD       (IorD),
        .IRWrite    (IRWrite),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemtoReg   (MemtoReg),
        .Regwrite   (Regwrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .PCSource   (PCSource),
        .instr_done (instr_done),
        .timeout_err(timeout_err),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    assign act = {PCWrite, Branch, IorD, IRWrite, MemRead, MemWrite, MemtoReg, Regwrite,
                  ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, timeout_err, illegal_op};

    function automatic logic [16:0] cw(input logic pcw, br, iord, irw, mr, mw,
                                       input logic [1:0] mtr, input logic rw,
                                       input logic [1:0] a, b, op,
                                       input logic pcs, done);
        return {pcw, br, iord, irw, mr, mw, mtr, rw, a, b, op, pcs, done};
    endfunction

    function automatic logic rbit();
        return ($urandom_range(1, 0) == 1);
    endfunction

    function automatic logic is_legal(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111};
    endfunction

    task automatic check(input string tag, input logic [16:0] e);
        logic [18:0] exp_v;
        exp_v = {e, exp_to, exp_ill};
        n_cmp++;
        assert (act === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, act, exp_v);
        end
    endtask

    // One clock cycle: drive mem_ready, compare at the falling edge, step past the rising edge.
    task automatic cycle(input logic rdy, input logic [16:0] e, input string tag);
        mem_ready = rdy;
        @(negedge clk);
        check(tag, e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        exp_to    = 1'b0;
        exp_ill   = 1'b0;
        @(posedge clk);
        #1;
        check("reset", V_ZERO);
        rst_n = 1'b1;
        cycle(rbit(), V_ZERO, "idle");
    endtask

    // waits consecutive not-ready cycles; the wait with index TIMEOUT traps.
    task automatic wait_phase(input logic [16:0] base, input logic [16:0] rdy_vec,
                              input int waits, input string tag, output bit trapped);
        trapped = 1'b0;
        for (int i = 0; i < waits; i++) begin
            cycle(1'b0, base, tag);
            if (i == TIMEOUT) begin
                trapped = 1'b1;
                exp_to  = 1'b1;
                return;
            end
        end
        cycle(1'b1, rdy_vec, tag);
    endtask

    task automatic trap_phase();
        repeat (3) cycle(rbit(), V_ZERO, "trap");
        do_reset();
    endtask

    task automatic run_instr(input logic [6:0] op, input int fw, input int mw);
        bit tr;
        Opcode = op;
        wait_phase(V_FETCH, V_FETCH_RDY, fw, "fetch", tr);
        if (tr) begin
            trap_phase();
            return;
        end
        if (!is_legal(op)) begin
`ifdef ILLEGAL_TRAP_EN
            cycle(rbit(), V_DECODE, "decode_illegal");
            exp_ill = 1'b1;
            trap_phase();
`else
            cycle(rbit(), V_NOP, "decode_nop");
`endif
            return;
        end
        cycle(rbit(), V_DECODE, "decode");
        case (op)
            7'b0110011: begin
                cycle(rbit(), V_EXEC_R, "exec_r");
                cycle(rbit(), V_WB_ALU, "wb_alu");
            end
            7'b0010011: begin
                cycle(rbit(), V_EXEC_I, "exec_i");
                cycle(rbit(), V_WB_ALU, "wb_alu");
            end
            7'b0000011: begin
                cycle(rbit(), V_MEM_ADDR, "mem_addr");
                wait_phase(V_MEM_RD, V_MEM_RD, mw, "mem_rd", tr);
                if (tr) begin
                    trap_phase();
                    return;
                end
                cycle(rbit(), V_WB_MEM, "wb_mem");
            end
            7'b0100011: begin
                cycle(rbit(), V_MEM_ADDR, "mem_addr");
                wait_phase(V_MEM_WR, V_MEM_WR_RDY, mw, "mem_wr", tr);
                if (tr) trap_phase();
            end
            7'b1100011: cycle(rbit(), V_BRANCH, "branch");
            default:    cycle(rbit(), V_JAL, "jal");
        endcase
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [6:0] rop;
        int         kind;
        int         fw;
        int         mw;

        V_ZERO       = '0;
        V_FETCH      = cw(0, 0, 0, 0, 1, 0, 2'b00, 0, 2'b00, 2'b01, 2'b00, 0, 0);
        V_FETCH_RDY  = cw(1, 0, 0, 1, 1, 0, 2'b00, 0, 2'b00, 2'b01, 2'b00, 0, 0);
        V_DECODE     = cw(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b10, 2'b10, 2'b00, 0, 0);
        V_NOP        = cw(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b10, 2'b10, 2'b00, 0, 1);
        V_EXEC_R     = cw(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 2'b10, 0, 0);
        V_EXEC_I     = cw(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b10, 2'b11, 0, 0);
        V_WB_ALU     = cw(0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 2'b00, 0, 1);
        V_MEM_ADDR   = cw(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b10, 2'b00, 0, 0);
        V_MEM_RD     = cw(0, 0, 1, 0, 1, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        V_WB_MEM     = cw(0, 0, 0, 0, 0, 0, 2'b01, 1, 2'b00, 2'b00, 2'b00, 0, 1);
        V_MEM_WR     = cw(0, 0, 1, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        V_MEM_WR_RDY = cw(0, 0, 1, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 1);
        V_BRANCH     = cw(0, 1, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 2'b01, 1, 1);
        V_JAL        = cw(1, 0, 0, 0, 0, 0, 2'b10, 1, 2'b00, 2'b00, 2'b00, 1, 1);

        Opcode = 7'b0110011;
        do_reset();

        run_instr(7'b0110011, 0, 0);
        run_instr(7'b0000011, 0, 3);
        run_instr(7'b0100011, 2, 0);
        run_instr(7'b0100011, 0, 4);
        run_instr(7'b1100011, 0, 0);
        run_instr(7'b1101111, 1, 0);
        run_instr(7'b0010011, 0, 0);
        run_instr(7'b1111111, 0, 0);
        run_instr(7'b0110011, 15, 0);
        run_instr(7'b0110011, 16, 0);
        run_instr(7'b0000011, 0, 15);
        run_instr(7'b0000011, 0, 16);
        run_instr(7'b0100011, 0, 16);

        // Asynchronous reset while a load waits in the memory read state.
        Opcode = 7'b0000011;
        cycle(1'b1, V_FETCH_RDY, "fetch");
        cycle(1'b0, V_DECODE, "decode");
        cycle(1'b0, V_MEM_ADDR, "mem_addr");
        cycle(1'b0, V_MEM_RD, "mem_rd");
        mem_ready = 1'b0;
        #2;
        check("mem_rd_pre_reset", V_MEM_RD);
        rst_n = 1'b0;
        #1;
        check("reset_async", V_ZERO);
        do_reset();

        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(6, 0);
            case (kind)
                0: rop = 7'b0110011;
                1: rop = 7'b0010011;
                2: rop = 7'b0000011;
                3: rop = 7'b0100011;
                4: rop = 7'b1100011;
                5: rop = 7'b1101111;
                default: begin
                    rop = 7'($urandom);
                    while (is_legal(rop)) rop = 7'($urandom);
                end
            endcase
            fw = ($urandom_range(11, 0) == 0) ? 16 : $urandom_range(4, 0);
            mw = ($urandom_range(11, 0) == 0) ? 16 : $urandom_range(TIMEOUT, 0);
            run_instr(rop, fw, mw);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
